// File: rtl/gf_pcpi_pkg.sv
// Shared types and GF coprocessor instruction constants for the PCPI initiator
// and the responders it talks to.
package gf_pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [6:0] OPCODE_R  = 7'b0110011;
  localparam logic [6:0] FUNCT7_GF = 7'b0000100;

  localparam logic [2:0] FUNCT3_CLMUL  = 3'd0;
  localparam logic [2:0] FUNCT3_GFADD  = 3'd1;
  localparam logic [2:0] FUNCT3_REDUCE = 3'd2;
  localparam logic [2:0] FUNCT3_MULT   = 3'd4;

  // Width-set instruction encoding
  localparam logic [6:0] OPCODE_S = 7'b0100011;
  localparam logic [2:0] FUNCT3_S = 3'b100;

endpackage

// File: rtl/pcpi_timeout_counter.sv
// Counts consecutive idle ISSUE cycles; expired pulses in the cycle that
// completes the TIMEOUT_CYCLES-th idle cycle.
module pcpi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  input  logic hold,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST     = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           count <= '0;
    else if (clear || hold)                count <= '0;
    else if (enable && count != TERMINAL)  count <= count + 1'b1;
  end

  // Fires combinationally so the FSM can leave ISSUE on the same edge that
  // would take the count to TIMEOUT_CYCLES.
  assign expired = enable && !hold && !clear && (count == LAST);

endmodule

// File: rtl/gf_pcpi_initiator.sv
// Single-outstanding PCPI initiator: accepts a command, drives it to a
// coprocessor, and returns its result or a timeout error.
module gf_pcpi_initiator
  import gf_pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        busy
);

  state_t state, state_next;
  logic   live;
  logic   cmd_fire;
  logic   in_issue;
  logic   expired;

  assign in_issue  = (state == ST_ISSUE);
  assign cmd_ready = live && (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // live keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) live <= 1'b0;
    else         live <= 1'b1;
  end

  pcpi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (cmd_fire),
    .enable  (in_issue && !pcpi_ready),
    .hold    (in_issue && pcpi_wait),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (cmd_fire)                 state_next = ST_ISSUE;
      ST_ISSUE: if (pcpi_ready || expired)    state_next = ST_RESP;
      ST_RESP:  if (rsp_ready)                state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // NOTE: these are plain datapath registers, not memories, so they take the
  // async reset and read back as zero while resetn is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
    end else if (cmd_fire) begin
      pcpi_insn <= cmd_insn;
      pcpi_rs1  <= cmd_rs1;
      pcpi_rs2  <= cmd_rs2;
    end
  end

  // A responder answer in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_data <= '0;
      rsp_wr   <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (in_issue) begin
      if (pcpi_ready) begin
        rsp_data <= pcpi_rd;
        rsp_wr   <= pcpi_wr;
        rsp_err  <= 1'b0;
      end else if (expired) begin
        rsp_data <= '0;
        rsp_wr   <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign pcpi_valid = in_issue;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_gf_pcpi_initiator.sv
// Directed bench for gf_pcpi_initiator; the bench drives the responder side
// with hand-computed GF results.
module tb_gf_pcpi_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr, rsp_err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  gf_pcpi_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_insn   (cmd_insn),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_wr     (rsp_wr),
    .rsp_err    (rsp_err),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_responder();
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
  endtask

  // Handshake one command; returns in the first ISSUE cycle.
  task automatic issue(input string tag, input logic [31:0] insn,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    cmd_valid = 1'b1;
    cmd_insn  = insn;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0;
    cmd_insn  = 32'hFFFF_FFFF;
    cmd_rs1   = 32'hFFFF_FFFF;
    cmd_rs2   = 32'hFFFF_FFFF;
    check({tag, "_pcpi_valid"}, {31'b0, pcpi_valid}, 32'd1);
    check({tag, "_pcpi_insn"},  pcpi_insn, insn);
    check({tag, "_busy_ready"}, {30'b0, busy, cmd_ready}, 32'b10);
  endtask

  task automatic respond(input logic [31:0] rd, input logic wr);
    pcpi_ready = 1'b1;
    pcpi_rd    = rd;
    pcpi_wr    = wr;
    cyc();
    quiet_responder();
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] data,
                            input logic wr, input logic err);
    check({tag, "_rsp_valid"}, {30'b0, rsp_valid, pcpi_valid}, 32'b10);
    check({tag, "_rsp_data"},  rsp_data, data);
    check({tag, "_rsp_wr_err"}, {30'b0, rsp_wr, rsp_err}, {30'b0, wr, err});
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check({tag, "_back_idle"}, {29'b0, rsp_valid, busy, cmd_ready}, 32'b001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_insn  = 32'h0;
    cmd_rs1   = 32'h0;
    cmd_rs2   = 32'h0;
    rsp_ready = 1'b0;
    quiet_responder();

    // Reset state, held across clock edges
    #2;
    check("rst_ctrl", {27'b0, cmd_ready, pcpi_valid, rsp_valid, busy, rsp_err}, 32'b0);
    cyc();
    cyc();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_data", rsp_data | pcpi_insn | pcpi_rs1 | pcpi_rs2, 32'h0);
    resetn = 1'b1;
    #1;
    check("rel_cmd_ready_pre_edge", {31'b0, cmd_ready}, 32'd0);
    cyc();
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // GF add 0x5 ^ 0xA = 0xF, with two wait cycles first
    issue("gfadd", 32'h082091B3, 32'h5, 32'hA);
    pcpi_wait = 1'b1;
    cyc();
    cyc();
    check("gfadd_wait_valid", {31'b0, pcpi_valid}, 32'd1);
    pcpi_wait = 1'b0;
    respond(32'h0000000F, 1'b1);
    expect_rsp("gfadd", 32'h0000000F, 1'b1, 1'b0);
    consume("gfadd");

    // Carry-less 0xA x 0xE = 0x1C ^ 0x70 = 0x6C; operands stable while valid
    issue("clmul", 32'h082081B3, 32'hA, 32'hE);
    for (int i = 0; i < 3; i++) begin
      pcpi_wait = 1'b1;
      cyc();
      check("clmul_stable", pcpi_insn ^ 32'h082081B3 | pcpi_rs1 ^ 32'hA | pcpi_rs2 ^ 32'hE, 32'h0);
    end
    pcpi_wait = 1'b0;
    check("clmul_rs_before_ready", {pcpi_rs1[15:0], pcpi_rs2[15:0]}, 32'h000A_000E);
    respond(32'h0000006C, 1'b1);
    expect_rsp("clmul", 32'h0000006C, 1'b1, 1'b0);
    consume("clmul");

    // Integer multiply 3*4, ready in the first ISSUE cycle (minimum latency)
    issue("mult", 32'h0820C1B3, 32'd3, 32'd4);
    respond(32'h0000000C, 1'b1);
    expect_rsp("mult", 32'h0000000C, 1'b1, 1'b0);
    consume("mult");

    // Silent responder: rsp_valid exactly 17 cycles after acceptance
    issue("tmo", 32'h00000013, 32'h1, 32'h2);
    pcpi_rd = 32'hDEAD_BEEF;
    pcpi_wr = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      cyc();
      check("tmo_not_yet", {30'b0, rsp_valid, pcpi_valid}, 32'b01);
    end
    cyc();
    quiet_responder();
    expect_rsp("tmo", 32'h0, 1'b0, 1'b1);

    // Backpressure in RESP; late pcpi_ready must be ignored
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'h1234_5678;
    pcpi_wr    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_hold", {28'b0, rsp_valid, rsp_err, rsp_wr, cmd_ready}, 32'b1100);
      check("bp_data", rsp_data, 32'h0);
    end
    quiet_responder();
    consume("tmo");

    // Long wait: 40 wait cycles then 10 silent cycles, no timeout
    issue("wait", 32'h082091B3, 32'h3, 32'h6);
    pcpi_wait = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    check("wait_still_issue", {30'b0, rsp_valid, pcpi_valid}, 32'b01);
    pcpi_wait = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("wait_silent_issue", {30'b0, rsp_valid, pcpi_valid}, 32'b01);
    respond(32'h0000_0005, 1'b0);
    expect_rsp("wait", 32'h0000_0005, 1'b0, 1'b0);
    consume("wait");

    // pcpi_ready in the expiry cycle wins over the timeout
    issue("tie", 32'h082081B3, 32'h7, 32'h7);
    for (int i = 0; i < 15; i++) cyc();
    check("tie_pre", {30'b0, rsp_valid, pcpi_valid}, 32'b01);
    respond(32'h0000_00A5, 1'b1);
    expect_rsp("tie", 32'h0000_00A5, 1'b1, 1'b0);
    consume("tie");

    // Reset mid-ISSUE: drop pcpi_valid immediately, no response
    issue("rst_mid", 32'h082091B3, 32'h9, 32'h9);
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    check("rst_mid_async", {28'b0, pcpi_valid, rsp_valid, busy, cmd_ready}, 32'b0);
    check("rst_mid_insn", pcpi_insn, 32'h0);
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'hBAD0_BAD0;
    cyc();
    cyc();
    quiet_responder();
    resetn = 1'b1;
    cyc();
    check("rst_mid_after", {29'b0, rsp_valid, busy, cmd_ready}, 32'b001);
    check("rst_mid_data", rsp_data, 32'h0);

    issue("post_rst", 32'h082091B3, 32'h30, 32'h0C);
    respond(32'h0000_003C, 1'b1);
    expect_rsp("post_rst", 32'h0000_003C, 1'b1, 1'b0);
    consume("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
